// File: rtl/basic_switch_led_pkg.sv
// Shared types and constants for the switch-to-LED I/O block.
package basic_switch_led_pkg;

    localparam int LED_W = 8;

    localparam logic [LED_W-1:0] LED_STARTUP_PATTERN = 8'h80;
    localparam logic [LED_W-1:0] LED_RESET_VALUE     = 8'h00;

    localparam int DEFAULT_STARTUP_CYCLES = 32;
    localparam int DEFAULT_POLL_DIV       = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STARTUP = 2'd1,
        RUN     = 2'd2
    } state_t;

    // Counter width for a modulus of n; a modulus of 1 still needs one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs; 2-clock latency, no handshake.
module sync_2ff #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/basic_switch_led.sv
// Mirrors synchronized slide switches onto LEDs after a power-on indication.
// Latency 3..POLL_DIV+2 clocks from a switch change; no backpressure, LEDS only move on poll edges.
module basic_switch_led
    import basic_switch_led_pkg::*;
#(
    parameter int STARTUP_CYCLES = DEFAULT_STARTUP_CYCLES,
    parameter int POLL_DIV       = DEFAULT_POLL_DIV
) (
    input  logic             CLK_IN,
    input  logic             RESET_IN,
    input  logic [LED_W-1:0] SWITCHES,
    output logic [LED_W-1:0] LEDS
);

    localparam int SCW = cnt_width(STARTUP_CYCLES);
    localparam int PCW = cnt_width(POLL_DIV);

    // Terminal counts kept at full 32-bit width so the compare never truncates.
    localparam logic [31:0] ST_LAST   = 32'(STARTUP_CYCLES - 1);
    localparam logic [31:0] POLL_LAST = 32'(POLL_DIV - 1);

    logic [LED_W-1:0] sw_sync;

    state_t           state_q, state_d;
    logic [SCW-1:0]   st_cnt_q, st_cnt_d;
    logic [PCW-1:0]   poll_cnt_q, poll_cnt_d;
    logic [LED_W-1:0] leds_q, leds_d;

    sync_2ff #(
        .WIDTH (LED_W)
    ) u_sw_sync (
        .clk_i (CLK_IN),
        .rst_i (RESET_IN),
        .d_i   (SWITCHES),
        .q_o   (sw_sync)
    );

    always_ff @(posedge CLK_IN or posedge RESET_IN) begin
        if (RESET_IN) begin
            state_q    <= IDLE;
            st_cnt_q   <= '0;
            poll_cnt_q <= '0;
            leds_q     <= LED_RESET_VALUE;
        end else begin
            state_q    <= state_d;
            st_cnt_q   <= st_cnt_d;
            poll_cnt_q <= poll_cnt_d;
            leds_q     <= leds_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        st_cnt_d   = st_cnt_q;
        poll_cnt_d = poll_cnt_q;
        leds_d     = leds_q;

        unique case (state_q)
            IDLE: begin
                state_d  = STARTUP;
                st_cnt_d = '0;
                leds_d   = LED_STARTUP_PATTERN;
            end
            STARTUP: begin
                // The pattern stays up through this edge; the first poll replaces it.
                if (32'(st_cnt_q) == ST_LAST) begin
                    state_d    = RUN;
                    poll_cnt_d = '0;
                end else begin
                    st_cnt_d = st_cnt_q + SCW'(1);
                end
            end
            RUN: begin
                if (32'(poll_cnt_q) == POLL_LAST) begin
                    poll_cnt_d = '0;
                    leds_d     = sw_sync;
                end else begin
                    poll_cnt_d = poll_cnt_q + PCW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign LEDS = leds_q;

endmodule

// File: tb/tb_basic_switch_led.sv
// Directed bench: default-parameter instance plus a POLL_DIV=1/STARTUP_CYCLES=1 instance.
module tb_basic_switch_led;

    localparam int S  = 32;
    localparam int P  = 8;
    localparam int SB = 1;
    localparam int PB = 1;

    logic       clk;
    logic       rst_a, rst_b;
    logic [7:0] sw_a, sw_b;
    logic [7:0] leds_a, leds_b;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_poll = 0;

    typedef struct {
        logic [7:0] sw;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [8];

    basic_switch_led #(
        .STARTUP_CYCLES (S),
        .POLL_DIV       (P)
    ) u_dut_a (
        .CLK_IN   (clk),
        .RESET_IN (rst_a),
        .SWITCHES (sw_a),
        .LEDS     (leds_a)
    );

    basic_switch_led #(
        .STARTUP_CYCLES (SB),
        .POLL_DIV       (PB)
    ) u_dut_b (
        .CLK_IN   (clk),
        .RESET_IN (rst_b),
        .SWITCHES (sw_b),
        .LEDS     (leds_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] cur(input int which);
        return (which != 0) ? leds_b : leds_a;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Counts edges until the selected LEDS equals exp; records the poll edge for instance A.
    task automatic wait_val(input int which, input logic [7:0] exp, input int maxc,
                            input string nm, output int took);
        bit ok;
        ok   = 1'b0;
        took = 0;
        while (took < maxc && !ok) begin
            @(posedge clk);
            #1;
            took++;
            if (cur(which) == exp) ok = 1'b1;
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %0h after %0d clocks, expected %0h", nm, cur(which), took, exp);
        end else if (which == 0) begin
            last_poll = cyc;
        end
    endtask

    // Counts edges for which LEDS keeps value val; returns count and the value that ended it.
    task automatic hold_cnt(input int which, input logic [7:0] val, input int maxc,
                            output int took, output logic [7:0] fin);
        took = 0;
        fin  = val;
        while (took < maxc && fin == val) begin
            @(posedge clk);
            #1;
            took++;
            fin = cur(which);
        end
    endtask

    initial begin
        int         took;
        int         glitches;
        logic [7:0] fin;

        vecs[0] = '{sw: 8'hA5, exp: 8'hA5};
        vecs[1] = '{sw: 8'h3C, exp: 8'h3C};
        vecs[2] = '{sw: 8'h01, exp: 8'h01};
        vecs[3] = '{sw: 8'h80, exp: 8'h80};
        vecs[4] = '{sw: 8'h00, exp: 8'h00};
        vecs[5] = '{sw: 8'hFF, exp: 8'hFF};
        vecs[6] = '{sw: 8'hC3, exp: 8'hC3};
        vecs[7] = '{sw: 8'h7E, exp: 8'h7E};

        rst_a = 1'b0;
        rst_b = 1'b1;
        sw_a  = 8'h00;
        sw_b  = 8'h3C;

        #100 rst_a = 1'b1;
        #500;
        chk("reset_leds_a", 32'(leds_a), 32'h00);
        chk("reset_leds_b", 32'(leds_b), 32'h00);
        #500 rst_a = 1'b0;

        // Pattern appears on the first edge and is held through STARTUP plus one poll period.
        @(posedge clk);
        #1;
        chk("alive_first_edge", 32'(leds_a), 32'h80);
        hold_cnt(0, 8'h80, S + P + 3, took, fin);
        chk("startup_hold_len", 32'(took), 32'(S + P));
        chk("startup_exit_val", 32'(fin), 32'h00);

        repeat (100) @(posedge clk);
        #1;
        sw_a = 8'hFF;
        wait_val(0, 8'hFF, P + 2, "run_ff_1", took);
        chk("lat_min_ff_1", 32'(took >= 3), 32'd1);
        sw_a = 8'h00;
        wait_val(0, 8'h00, P + 2, "run_00", took);
        chk("lat_min_00", 32'(took >= 3), 32'd1);
        sw_a = 8'hFF;
        wait_val(0, 8'hFF, P + 2, "run_ff_2", took);

        foreach (vecs[i]) begin
            sw_a = vecs[i].sw;
            repeat (P + 4) @(posedge clk);
            #1;
            chk($sformatf("vec%0d", i), 32'(leds_a), 32'(vecs[i].exp));
        end

        // Single-cycle pulse placed so the poll edge falls well away from it.
        sw_a = 8'h00;
        wait_val(0, 8'h00, P + 2, "pulse_setup", took);
        while (((cyc + 3 - last_poll) % P) != P / 2) begin
            @(posedge clk);
            #1;
        end
        sw_a = 8'h01;
        @(posedge clk);
        #1;
        sw_a = 8'h00;
        glitches = 0;
        repeat (3 * P) begin
            @(posedge clk);
            #1;
            if (leds_a != 8'h00) glitches++;
        end
        chk("pulse_ignored", 32'(glitches), 32'd0);

        // Asynchronous reset between edges, then a switch change while in STARTUP.
        sw_a = 8'hFF;
        wait_val(0, 8'hFF, P + 2, "pre_reset_ff", took);
        @(posedge clk);
        #3 rst_a = 1'b1;
        #1;
        chk("async_reset_clear", 32'(leds_a), 32'h00);
        @(posedge clk);
        #1 rst_a = 1'b0;
        @(posedge clk);
        #1;
        chk("realive_first_edge", 32'(leds_a), 32'h80);
        sw_a = 8'h5A;
        hold_cnt(0, 8'h80, S + P + 3, took, fin);
        chk("restart_hold_len", 32'(took), 32'(S + P));
        chk("startup_sw_5a", 32'(fin), 32'h5A);

        // Switches parked at the pattern value: no visible change across STARTUP->RUN.
        sw_a = 8'h80;
        @(posedge clk);
        #1 rst_a = 1'b1;
        @(posedge clk);
        #1 rst_a = 1'b0;
        glitches = 0;
        @(posedge clk);
        #1;
        chk("stable80_first_edge", 32'(leds_a), 32'h80);
        repeat (S + 4 * P) begin
            @(posedge clk);
            #1;
            if (leds_a != 8'h80) glitches++;
        end
        chk("stable80_no_glitch", 32'(glitches), 32'd0);

        // Minimal-parameter instance: one STARTUP clock, then a poll every clock.
        @(posedge clk);
        #1 rst_b = 1'b0;
        @(posedge clk);
        #1;
        chk("b_alive_edge", 32'(leds_b), 32'h80);
        @(posedge clk);
        #1;
        chk("b_startup_exit_edge", 32'(leds_b), 32'h80);
        @(posedge clk);
        #1;
        chk("b_first_poll", 32'(leds_b), 32'h3C);
        sw_b = 8'hC3;
        wait_val(1, 8'hC3, 6, "b_c3", took);
        chk("b_latency_c3", 32'(took), 32'd3);
        sw_b = 8'h18;
        wait_val(1, 8'h18, 6, "b_18", took);
        chk("b_latency_18", 32'(took), 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200us;
        $display("FAIL watchdog: simulation still running at 200us, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
